// File: rtl/acc_s.sv
// acc_s: saturating signed block accumulator.
//   Sums LEN consecutive signed samples per block. Each addition saturates
//   to the WIDTH-bit signed range. Sticky per-block overflow/underflow flags
//   are returned with the block sum over a valid/ready handshake.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous active-high reset
//   clr       - synchronous abandon of the partial block
//   in_valid  - in_data valid
//   in_ready  - a sample is accepted this cycle when in_valid is also high
//   in_data   - signed sample (WIDTH bits)
//   out_valid - block result valid
//   out_ready - consumer accepts result
//   out_sum   - signed saturated block sum (WIDTH bits)
//   out_of    - some step of the block saturated positive
//   out_uf    - some step of the block saturated negative
module acc_s #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_of,
    output logic             out_uf
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_of;
    logic             r_uf;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_oof;
    logic             r_ouf;

    logic             w_accept;
    logic [WIDTH:0]   w_s;
    logic             w_pos;
    logic             w_neg;
    logic [WIDTH-1:0] w_step;
    logic             w_of;
    logic             w_uf;

    assign in_ready = !rst && !clr && (r_state == ACC || out_ready);
    assign w_accept = in_valid && in_ready;

    // One extra bit of headroom: the two top bits disagree exactly when the
    // true sum leaves the WIDTH-bit signed range.
    assign w_s   = {r_acc[WIDTH-1], r_acc} + {in_data[WIDTH-1], in_data};
    assign w_pos = !w_s[WIDTH] &&  w_s[WIDTH-1];
    assign w_neg =  w_s[WIDTH] && !w_s[WIDTH-1];
    assign w_of  = r_of | w_pos;
    assign w_uf  = r_uf | w_neg;

    always_comb begin
        w_step = w_s[WIDTH-1:0];
        if (w_pos)
            w_step = {1'b0, {(WIDTH-1){1'b1}}};
        else if (w_neg)
            w_step = {1'b1, {(WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_of    <= 1'b0;
            r_uf    <= 1'b0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_oof   <= 1'b0;
            r_ouf   <= 1'b0;
        end else begin
            // Result consumed; a completing accept below overrides this.
            if (r_state == HOLD && out_ready) begin
                r_state <= ACC;
                r_valid <= 1'b0;
            end
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_of  <= 1'b0;
                r_uf  <= 1'b0;
            end else if (w_accept) begin
                if (r_cnt == LAST) begin
                    r_sum   <= w_step;
                    r_oof   <= w_of;
                    r_ouf   <= w_uf;
                    r_valid <= 1'b1;
                    r_state <= HOLD;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_of    <= 1'b0;
                    r_uf    <= 1'b0;
                end else begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                    r_of  <= w_of;
                    r_uf  <= w_uf;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_of    = r_oof;
    assign out_uf    = r_ouf;

endmodule

// File: tb/tb_acc_s.sv
module tb_acc_s;

    localparam int W    = 4;
    localparam int POSL = 7;
    localparam int NEGL = -8;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         rdy4, vld4, of4, uf4;
    logic [W-1:0] sum4;
    logic         rdy1, vld1, of1, uf1;
    logic [W-1:0] sum1;

    int n_vec = 0;
    int n_bad = 0;

    acc_s #(.WIDTH(W), .LEN(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .out_valid(vld4), .out_ready(out_ready),
        .out_sum(sum4), .out_of(of4), .out_uf(uf4)
    );

    acc_s #(.WIDTH(W), .LEN(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(vld1), .out_ready(out_ready),
        .out_sum(sum1), .out_of(of1), .out_uf(uf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- reference model (index 0: LEN=4, index 1: LEN=1) ----
    int  m_len [2] = '{4, 1};
    int  m_blk [2][16];
    int  m_n   [2];
    bit  m_hold[2];
    int  m_sum [2];
    bit  m_of  [2];
    bit  m_uf  [2];

    // Fold a completed block with per-step clamping.
    task automatic sat_sum(input int k, output int s, output bit of_, output bit uf_);
        s = 0; of_ = 0; uf_ = 0;
        for (int i = 0; i < m_len[k]; i++) begin
            s = s + m_blk[k][i];
            if (s > POSL) begin s = POSL; of_ = 1; end
            else if (s < NEGL) begin s = NEGL; uf_ = 1; end
        end
    endtask

    function automatic bit m_ready(int k);
        return !rst && !clr && (!m_hold[k] || out_ready);
    endfunction

    task automatic m_step(input int k);
        bit acc;
        if (rst) begin
            m_n[k] = 0; m_hold[k] = 0; m_sum[k] = 0; m_of[k] = 0; m_uf[k] = 0;
        end else begin
            acc = in_valid && m_ready(k);
            if (m_hold[k] && out_ready) m_hold[k] = 0;
            if (clr) m_n[k] = 0;
            else if (acc) begin
                m_blk[k][m_n[k]] = int'($signed(in_data));
                m_n[k]++;
                if (m_n[k] == m_len[k]) begin
                    sat_sum(k, m_sum[k], m_of[k], m_uf[k]);
                    m_hold[k] = 1;
                    m_n[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are set before the call (just after an edge); ready is checked
    // mid-cycle, outputs one time unit after the next rising edge.
    task automatic cyc();
        #4;
        chk("in_ready4", int'(rdy4), int'(m_ready(0)));
        chk("in_ready1", int'(rdy1), int'(m_ready(1)));
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
        chk("out_valid4", int'(vld4), int'(m_hold[0]));
        chk("out_sum4",   int'($signed(sum4)), m_sum[0]);
        chk("out_of4",    int'(of4), int'(m_of[0]));
        chk("out_uf4",    int'(uf4), int'(m_uf[0]));
        chk("out_valid1", int'(vld1), int'(m_hold[1]));
        chk("out_sum1",   int'($signed(sum1)), m_sum[1]);
        chk("out_of1",    int'(of1), int'(m_of[1]));
        chk("out_uf1",    int'(uf1), int'(m_uf[1]));
    endtask

    task automatic drive(input bit r, input bit c, input bit v, input int d, input bit o);
        rst = r; clr = c; in_valid = v; in_data = W'(d); out_ready = o;
        cyc();
    endtask

    task automatic flush();
        drive(0, 1, 0, 0, 1);
    endtask

    typedef struct {
        int  s[4];
        int  sum;
        bit  of_;
        bit  uf_;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{s: '{1, 2, -1, 3},   sum: 5,  of_: 0, uf_: 0};
        tbl[1] = '{s: '{4, 4, -2, 1},   sum: 6,  of_: 1, uf_: 0};
        tbl[2] = '{s: '{7, 7, -8, -8},  sum: -8, of_: 1, uf_: 1};
        tbl[3] = '{s: '{-5, -5, 7, 7},  sum: 6,  of_: 0, uf_: 1};
        tbl[4] = '{s: '{-8, -1, 3, 0},  sum: -5, of_: 0, uf_: 1};

        // Reset
        drive(1, 0, 1, 3, 1);
        drive(1, 0, 1, 3, 1);
        chk("reset_valid", int'(vld4), 0);
        chk("reset_sum",   int'($signed(sum4)), 0);
        chk("reset_flags", int'({of4, uf4}), 0);

        // Table-driven blocks, back to back with out_ready=1
        for (int t = 0; t < 5; t++) begin
            flush();
            for (int i = 0; i < 4; i++) drive(0, 0, 1, tbl[t].s[i], 1);
            chk("tbl_valid", int'(vld4), 1);
            chk("tbl_sum",   int'($signed(sum4)), tbl[t].sum);
            chk("tbl_of",    int'(of4), int'(tbl[t].of_));
            chk("tbl_uf",    int'(uf4), int'(tbl[t].uf_));
            drive(0, 0, 0, 0, 1);
            chk("tbl_drop", int'(vld4), 0);
        end

        // Backpressure: hold result 5 cycles, then next block starts on release
        flush();
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 0);
            chk("bp_hold_sum", int'($signed(sum4)), 7);
            chk("bp_hold_of",  int'(of4), 1);
        end
        drive(0, 0, 1, 1, 1);
        chk("bp_release_valid", int'(vld4), 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1);
        chk("bp_next_sum", int'($signed(sum4)), 4);
        chk("bp_next_valid", int'(vld4), 1);

        // clr abandons a partial block
        flush();
        drive(0, 0, 1, 3, 1);
        drive(0, 0, 1, 3, 1);
        rst = 0; clr = 1; in_valid = 1; in_data = 4'd5; out_ready = 1;
        #4;
        chk("clr_ready", int'(rdy4), 0);
        @(posedge clk); m_step(0); m_step(1); #1;
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 1);
        chk("clr_sum", int'($signed(sum4)), 4);
        chk("clr_flags", int'({of4, uf4}), 0);
        // clr while holding leaves the result alone
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 0);
        chk("clr_hold_valid", int'(vld4), 1);
        chk("clr_hold_sum", int'($signed(sum4)), 4);

        // Reset mid-block
        flush();
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 2, 1);
        drive(1, 0, 1, 2, 1);
        chk("rst_valid", int'(vld4), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 1);
        chk("rst_after_sum", int'($signed(sum4)), 4);

        // LEN=1 full throughput
        flush();
        drive(0, 0, 1, 7, 1);
        chk("len1_a", int'($signed(sum1)), 7);
        drive(0, 0, 1, -8, 1);
        chk("len1_b", int'($signed(sum1)), -8);
        chk("len1_bv", int'(vld1), 1);
        drive(0, 0, 1, 3, 1);
        chk("len1_c", int'($signed(sum1)), 3);
        chk("len1_flags", int'({of1, uf1}), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(bit'($urandom_range(0, 99) == 0),
                  bit'($urandom_range(0, 19) == 0),
                  bit'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 15)) - 8,
                  bit'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
